// File: rtl/tile_buffer_pkg.sv
// Shared definitions for the tile_buffer unified buffer: FSM state encoding
// and the SDSU operand-type codes.
package tile_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic TYPE_ACT = 1'b0;
  localparam logic TYPE_WGT = 1'b1;

endpackage

// File: rtl/tile_buffer_fifo.sv
// Write-back queue for tile_buffer: first-word-fall-through synchronous FIFO
// with a simultaneous push/pop allowed even when full.
module tb_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tile_buffer.sv
// Unified tile buffer: loads a rows x cols tile from DRAM, streams it to the
// SDSU (row-major or transposed) and drains queued write-backs. UB_PERF_EN adds perf counters.
module tile_buffer
  import tile_buffer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DIM_W    = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 2,
  parameter int WB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic [ADDR_W-1:0] ctrl_src_addr,
  input  logic [DIM_W-1:0]  ctrl_rows,
  input  logic [DIM_W-1:0]  ctrl_cols,
  input  logic              ctrl_transpose,
  input  logic              ctrl_type,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic              sdsu_valid,
  output logic [DATA_W-1:0] sdsu_data,
  output logic              sdsu_type,
  output logic              sdsu_last,
  input  logic              sdsu_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic [31:0]       perf_load_cyc,
  output logic [31:0]       perf_stall_cyc
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int FW    = ADDR_W + DATA_W;
  localparam logic [RD_LAT-1:0] LOW_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] src_reg;
  logic [DIM_W-1:0]  rows_reg;
  logic [DIM_W-1:0]  cols_reg;
  logic              transpose_reg;
  logic              type_reg;
  logic [IDX_W-1:0]  n_reg;
  logic [IDX_W-1:0]  issue_idx_reg;
  logic [AW-1:0]     wr_idx_reg;
  logic [IDX_W-1:0]  fetch_cnt_reg;
  logic [AW-1:0]     cur_idx_reg;
  logic [DIM_W-1:0]  inner_reg;
  logic [DIM_W-1:0]  outer_reg;
  logic [RD_LAT-1:0] rd_vld_reg;
  logic [RD_LAT-1:0] rd_vld_next;
  logic              err_reg;
  logic              valid_reg;
  logic              last_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] tile_mem [DEPTH];

  logic [31:0]       tile_words;
  logic              cmd_fire;
  logic              cmd_empty;
  logic              cmd_too_big;
  logic              issuing;
  logic              issue_last;
  logic              ret_valid;
  logic              reads_drained;
  logic              fetch;
  logic              fetch_final;
  logic              accept;
  logic [DIM_W-1:0]  inner_lim;
  logic              inner_wrap;

  logic [FW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wb_push;
  logic              wb_pop;

  assign tile_words  = 32'(ctrl_rows) * 32'(ctrl_cols);
  assign cmd_fire    = ctrl_valid && (state_reg == IDLE);
  assign cmd_empty   = (ctrl_rows == '0) || (ctrl_cols == '0);
  assign cmd_too_big = tile_words > 32'(DEPTH);

  assign issuing       = (state_reg == LOAD);
  assign issue_last    = (issue_idx_reg == n_reg - IDX_W'(1));
  assign ret_valid     = rd_vld_reg[RD_LAT-1];
  // The oldest read may still be landing this cycle; its write completes
  // before the first registered read in STREAM.
  assign reads_drained = ((rd_vld_reg & LOW_MASK) == '0);

  assign accept      = valid_reg && sdsu_ready;
  assign fetch       = (state_reg == STREAM) && (fetch_cnt_reg != n_reg) &&
                       (!valid_reg || sdsu_ready);
  assign fetch_final = (fetch_cnt_reg == n_reg - IDX_W'(1));
  assign inner_lim   = transpose_reg ? rows_reg : cols_reg;
  assign inner_wrap  = (inner_reg == inner_lim - DIM_W'(1));

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_vld_next = issuing;
    end else begin : g_latn
      assign rd_vld_next = {rd_vld_reg[RD_LAT-2:0], issuing};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_empty)        state_next = DONE;
          else if (!cmd_too_big) state_next = LOAD;
        end
      end
      LOAD:   if (issue_last)          state_next = WAIT;
      WAIT:   if (reads_drained)       state_next = STREAM;
      STREAM: if (accept && last_reg)  state_next = DONE;
      DONE:                            state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      rows_reg      <= '0;
      cols_reg      <= '0;
      transpose_reg <= 1'b0;
      type_reg      <= TYPE_ACT;
      n_reg         <= '0;
      issue_idx_reg <= '0;
      wr_idx_reg    <= '0;
      fetch_cnt_reg <= '0;
      cur_idx_reg   <= '0;
      inner_reg     <= '0;
      outer_reg     <= '0;
      rd_vld_reg    <= '0;
      err_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_vld_reg <= rd_vld_next;
      err_reg    <= cmd_fire && !cmd_empty && cmd_too_big;

      if (cmd_fire) begin
        src_reg       <= ctrl_src_addr;
        rows_reg      <= ctrl_rows;
        cols_reg      <= ctrl_cols;
        transpose_reg <= ctrl_transpose;
        type_reg      <= ctrl_type;
        n_reg         <= IDX_W'(tile_words);
        issue_idx_reg <= '0;
        wr_idx_reg    <= '0;
        fetch_cnt_reg <= '0;
        cur_idx_reg   <= '0;
        inner_reg     <= '0;
        outer_reg     <= '0;
      end

      if (issuing)   issue_idx_reg <= issue_idx_reg + IDX_W'(1);
      if (ret_valid) wr_idx_reg    <= wr_idx_reg + AW'(1);

      // Add-only walk: row-major steps by 1; transposed steps by cols and
      // restarts at the next column base when the row counter wraps.
      if (fetch) begin
        valid_reg     <= 1'b1;
        last_reg      <= fetch_final;
        fetch_cnt_reg <= fetch_cnt_reg + IDX_W'(1);
        if (inner_wrap) begin
          inner_reg   <= '0;
          outer_reg   <= outer_reg + DIM_W'(1);
          cur_idx_reg <= transpose_reg ? AW'(outer_reg) + AW'(1)
                                       : cur_idx_reg + AW'(1);
        end else begin
          inner_reg   <= inner_reg + DIM_W'(1);
          cur_idx_reg <= cur_idx_reg + (transpose_reg ? AW'(cols_reg) : AW'(1));
        end
      end else if (accept) begin
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret_valid) tile_mem[wr_idx_reg] <= ram_data_in;
    if (fetch)     rd_data_reg <= tile_mem[cur_idx_reg];
  end

  assign ctrl_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign err        = err_reg;
  assign sdsu_valid = valid_reg;
  assign sdsu_data  = valid_reg ? rd_data_reg : '0;
  assign sdsu_last  = valid_reg && last_reg;
  assign sdsu_type  = type_reg;

  assign wb_ready = !fifo_full;
  assign wb_push  = wb_valid && wb_ready;
  assign wb_pop   = !fifo_empty && !issuing;

  tb_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wb_push),
    .push_data ({wb_addr, wb_data}),
    .pop       (wb_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Tile reads own the DRAM port during LOAD; write-backs take any other cycle.
  always_comb begin
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_addr     = '0;
    ram_data_out = '0;
    if (issuing) begin
      ram_ena  = 1'b1;
      ram_addr = src_reg + ADDR_W'(issue_idx_reg);
    end else if (wb_pop) begin
      ram_ena      = 1'b1;
      ram_wea      = 1'b1;
      ram_addr     = fifo_head[FW-1:DATA_W];
      ram_data_out = fifo_head[DATA_W-1:0];
    end
  end

`ifdef UB_PERF_EN
  logic [31:0] perf_load_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_load_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (((state_reg == LOAD) || (state_reg == WAIT)) && (perf_load_reg != '1))
        perf_load_reg <= perf_load_reg + 32'd1;
      if (valid_reg && !sdsu_ready && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_load_cyc  = perf_load_reg;
  assign perf_stall_cyc = perf_stall_reg;
`else
  assign perf_load_cyc  = 32'd0;
  assign perf_stall_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_tile_buffer.sv
// Scoreboard bench for tile_buffer: stimulus queues expected reads, stream
// elements and write-backs; a negedge monitor pops and compares them.
module tb_tile_buffer;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int DIM_W    = 10;
  localparam int DEPTH    = 1024;
  localparam int RD_LAT   = 2;
  localparam int WB_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ctrl_valid = 1'b0;
  logic              ctrl_ready;
  logic [ADDR_W-1:0] ctrl_src_addr = '0;
  logic [DIM_W-1:0]  ctrl_rows = '0;
  logic [DIM_W-1:0]  ctrl_cols = '0;
  logic              ctrl_transpose = 1'b0;
  logic              ctrl_type = 1'b0;
  logic              busy, done, err;
  logic              ram_ena, ram_wea;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;
  logic              sdsu_valid;
  logic [DATA_W-1:0] sdsu_data;
  logic              sdsu_type, sdsu_last;
  logic              sdsu_ready = 1'b1;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              wb_ready;
  logic [31:0]       perf_load_cyc, perf_stall_cyc;

  always #5 clk = ~clk;

  tile_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
    .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_src_addr(ctrl_src_addr), .ctrl_rows(ctrl_rows), .ctrl_cols(ctrl_cols),
    .ctrl_transpose(ctrl_transpose), .ctrl_type(ctrl_type),
    .busy(busy), .done(done), .err(err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .sdsu_valid(sdsu_valid), .sdsu_data(sdsu_data), .sdsu_type(sdsu_type),
    .sdsu_last(sdsu_last), .sdsu_ready(sdsu_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .perf_load_cyc(perf_load_cyc), .perf_stall_cyc(perf_stall_cyc)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stream [$];
  logic [31:0] exp_rd [$];
  logic [63:0] exp_wr [$];
  logic        exp_type = 1'b0;
  int done_cnt = 0, err_cnt = 0, stream_acc = 0, cyc = 0;
  int first_rd = -1, last_rd = -1;
  int stall_left = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endfunction

  // DRAM model: word at 0x100+i holds i+1, returned RD_LAT cycles later.
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (ram_ena && !ram_wea) ? (ram_addr - 32'h100 + 32'd1) : 32'h0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_data_in = rd_pipe[RD_LAT-1];

  // SDSU back-pressure: hold ready low while element 2 is offered.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && sdsu_valid && sdsu_data == 32'd2) begin
        sdsu_ready = 1'b0;
        stall_left--;
      end else begin
        sdsu_ready = 1'b1;
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    logic [63:0] w;
    cyc++;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {sdsu_valid, sdsu_last, sdsu_data}, prev_out);
      prev_stall = sdsu_valid && !sdsu_ready;
      prev_out   = {sdsu_valid, sdsu_last, sdsu_data};
      if (sdsu_valid && sdsu_ready) begin
        stream_acc++;
        $display("stream data=%0d last=%0b type=%0b", sdsu_data, sdsu_last, sdsu_type);
        if (exp_stream.size() == 0) unexpected("stream_extra", {32'h0, sdsu_data});
        else begin
          e = exp_stream.pop_front();
          chk("stream_data", {32'h0, sdsu_data}, {32'h0, e});
          chk("stream_last", {63'h0, sdsu_last}, {63'h0, exp_stream.size() == 0});
          chk("stream_type", {63'h0, sdsu_type}, {63'h0, exp_type});
        end
      end
      if (ram_ena) begin
        if (ram_wea) begin
          $display("dram write addr=%0h data=%0h", ram_addr, ram_data_out);
          if (exp_wr.size() == 0) unexpected("write_extra", {ram_addr, ram_data_out});
          else begin
            w = exp_wr.pop_front();
            chk("wb_order", {ram_addr, ram_data_out}, w);
            chk("wb_after_load", 64'(exp_rd.size()), 64'd0);
          end
        end else begin
          $display("dram read addr=%0h", ram_addr);
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          if (exp_rd.size() == 0) unexpected("read_extra", {32'h0, ram_addr});
          else begin
            e = exp_rd.pop_front();
            chk("read_addr", {32'h0, ram_addr}, {32'h0, e});
          end
        end
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  task automatic issue_cmd(input logic [31:0] src, input int rows, input int cols,
                           input logic tr, input logic typ);
    @(posedge clk); #1;
    ctrl_src_addr  = src;
    ctrl_rows      = rows[DIM_W-1:0];
    ctrl_cols      = cols[DIM_W-1:0];
    ctrl_transpose = tr;
    ctrl_type      = typ;
    ctrl_valid     = 1'b1;
    @(posedge clk); #1;
    ctrl_valid     = 1'b0;
  endtask

  task automatic wait_done(input int start, input string name);
    int t;
    t = 0;
    while (done_cnt == start && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    repeat (3) begin @(negedge clk); #1; end
    chk({name, "_done_pulses"}, 64'(done_cnt - start), 64'd1);
    chk({name, "_stream_left"}, 64'(exp_stream.size()), 64'd0);
    chk({name, "_reads_left"}, 64'(exp_rd.size()), 64'd0);
  endtask

  task automatic push_reads(input logic [31:0] src, input int n);
    for (int i = 0; i < n; i++) exp_rd.push_back(src + 32'(i));
  endtask

  logic [31:0] rm6 [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
  logic [31:0] tr6 [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};

  initial begin
    int s, se, t, base;
    logic [31:0] ps;

    #12;
    chk("rst_ready", {62'h0, ctrl_ready, wb_ready}, 64'h3);
    chk("rst_ctrl_out", {60'h0, busy, done, err, sdsu_valid}, 64'h0);
    chk("rst_data", {ram_ena, ram_wea, sdsu_last, sdsu_type, 28'h0, sdsu_data}, 64'h0);
    chk("rst_ram", {ram_addr, ram_data_out}, 64'h0);
    chk("rst_perf", {perf_load_cyc, perf_stall_cyc}, 64'h0);
    #1 reset = 1'b1;

    // Row-major 2x3, weight type
    exp_type = 1'b1;
    for (int i = 0; i < 6; i++) exp_stream.push_back(rm6[i]);
    push_reads(32'h100, 6);
    first_rd = -1;
    s = done_cnt;
    issue_cmd(32'h100, 2, 3, 1'b0, 1'b1);
    wait_done(s, "basic");
    chk("read_span", 64'(last_rd - first_rd), 64'd5);
`ifdef UB_PERF_EN
    chk("perf_load_counts", {63'h0, perf_load_cyc != 0}, 64'd1);
`endif

    // Transposed 2x3
    exp_type = 1'b0;
    for (int i = 0; i < 6; i++) exp_stream.push_back(tr6[i]);
    push_reads(32'h100, 6);
    s = done_cnt;
    issue_cmd(32'h100, 2, 3, 1'b1, 1'b0);
    wait_done(s, "transpose");

    // Back-pressure on element 2
    ps = perf_stall_cyc;
    stall_left = 3;
    for (int i = 0; i < 6; i++) exp_stream.push_back(rm6[i]);
    push_reads(32'h100, 6);
    s = done_cnt;
    issue_cmd(32'h100, 2, 3, 1'b0, 1'b0);
    wait_done(s, "backpressure");
    chk("stall_applied", 64'(stall_left), 64'd0);
`ifdef UB_PERF_EN
    chk("perf_stall", {32'h0, perf_stall_cyc - ps}, 64'd3);
`else
    chk("perf_stall", {32'h0, perf_stall_cyc}, 64'd0);
`endif

    // Oversized tile is rejected
    s = done_cnt;
    se = err_cnt;
    issue_cmd(32'h100, 40, 40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("reject_ctrl_ready", {63'h0, ctrl_ready}, 64'd1);
    end
    chk("reject_err", 64'(err_cnt - se), 64'd1);
    chk("reject_done", 64'(done_cnt - s), 64'd0);

    // Empty tile completes without access
    s = done_cnt;
    issue_cmd(32'h100, 0, 3, 1'b0, 1'b0);
    wait_done(s, "zero_rows");

    // Write-backs queued during a 3x4 load
    for (int i = 0; i < 12; i++) exp_stream.push_back(32'(i + 1));
    push_reads(32'h100, 12);
    for (int k = 0; k < 8; k++) exp_wr.push_back({32'h200 + 32'(k), 32'hA000 + 32'(k)});
    s = done_cnt;
    issue_cmd(32'h100, 3, 4, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wb_valid = 1'b1;
      wb_addr  = 32'h200 + 32'(k);
      wb_data  = 32'hA000 + 32'(k);
      @(negedge clk);
      chk("wb_ready_open", {63'h0, wb_ready}, 64'd1);
      @(posedge clk); #1;
    end
    wb_addr = 32'h2FF;
    wb_data = 32'hDEAD;
    @(negedge clk);
    chk("wb_full", {63'h0, wb_ready}, 64'd0);
    chk("wb_held_in_load", 64'(exp_wr.size()), 64'd8);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    wait_done(s, "wb_contention");
    repeat (5) begin @(negedge clk); #1; end
    chk("wb_drained", 64'(exp_wr.size()), 64'd0);

    // Asynchronous reset during STREAM
    for (int i = 0; i < 6; i++) exp_stream.push_back(rm6[i]);
    push_reads(32'h100, 6);
    s = done_cnt;
    base = stream_acc;
    issue_cmd(32'h100, 2, 3, 1'b0, 1'b0);
    t = 0;
    while (stream_acc < base + 2 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_mid_reached", 64'(stream_acc - base), 64'd2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", {59'h0, busy, done, err, ctrl_ready, wb_ready}, 64'h3);
    chk("rst_mid_stream", {ram_ena, sdsu_valid, sdsu_last, 29'h0, sdsu_data}, 64'h0);
    exp_stream.delete();
    exp_rd.delete();
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_mid_no_done", 64'(done_cnt - s), 64'd0);
    chk("rst_mid_perf", {perf_load_cyc, perf_stall_cyc}, 64'h0);

    // Fresh command after reset
    for (int i = 0; i < 6; i++) exp_stream.push_back(tr6[i]);
    push_reads(32'h100, 6);
    s = done_cnt;
    issue_cmd(32'h100, 2, 3, 1'b1, 1'b0);
    wait_done(s, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
